// File: rtl/mlp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mlp_pkg
// Description : Shared types and constants for the MLP core and its output
//               stages (FSM state encoding, index-width helper, Q-format split).
// Revision    : 1.0 - initial release
// ============================================================================
package mlp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_e;

    // Neuron output format used across the MLP datapath: Q(INT).(FRAC)
    localparam int unsigned MLP_WIDTH  = 8;
    localparam int unsigned INT_WIDTH  = MLP_WIDTH * 3 / 8;
    localparam int unsigned FRAC_WIDTH = MLP_WIDTH * 5 / 8;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mlp_argmax_stage.sv
`default_nettype none
// ============================================================================
// Module      : mlp_argmax_stage
// Description : Captures one signed neuron-output vector, scans it one element
//               per cycle and presents argmax index, value and tie flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mlp_argmax_stage
    import mlp_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned N     = 4,
    localparam int unsigned IDX_W = idx_w(N)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_data [N-1:0],
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [IDX_W-1:0]        out_index,
    output logic signed [WIDTH-1:0] out_value,
    output logic                    out_tie
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    state_e                  state_q;
    state_e                  state_d;
    logic signed [WIDTH-1:0] buf_q [N-1:0];
    logic [IDX_W-1:0]        idx_q;
    logic [IDX_W-1:0]        best_idx_q;
    logic signed [WIDTH-1:0] best_val_q;
    logic                    tie_q;
    logic                    accept;
    logic                    scan_last;

    assign accept    = in_valid && in_ready;
    assign scan_last = (idx_q == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = (N > 1) ? SCAN : HOLD;
                end
            end
            SCAN: begin
                if (scan_last) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE:    in_ready  = 1'b1;
            HOLD:    out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // Element 0 seeds the running best at capture; the scan starts at index 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                buf_q[i] <= '0;
            end
            idx_q      <= '0;
            best_idx_q <= '0;
            best_val_q <= '0;
            tie_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        for (int i = 0; i < N; i++) begin
                            buf_q[i] <= in_data[i];
                        end
                        best_val_q <= in_data[0];
                        best_idx_q <= '0;
                        tie_q      <= 1'b0;
                        idx_q      <= (N > 1) ? IDX_W'(1) : '0;
                    end
                end
                SCAN: begin
                    if (buf_q[idx_q] > best_val_q) begin
                        best_val_q <= buf_q[idx_q];
                        best_idx_q <= idx_q;
                        tie_q      <= 1'b0;
                    end else if (buf_q[idx_q] == best_val_q) begin
                        tie_q      <= 1'b1;
                    end
                    if (!scan_last) begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: begin
                    idx_q <= idx_q;
                end
            endcase
        end
    end

    assign out_index = best_idx_q;
    assign out_value = best_val_q;
    assign out_tie   = tie_q;

endmodule
`default_nettype wire

// File: tb/tb_mlp_argmax_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mlp_argmax_stage
// Description : Directed self-checking bench for mlp_argmax_stage (WIDTH=8, N=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mlp_argmax_stage;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] in_data [3:0];
    logic              out_valid;
    logic              out_ready;
    logic [1:0]        out_index;
    logic [7:0]        out_value;
    logic              out_tie;

    int n_checks = 0;
    int n_fail   = 0;

    mlp_argmax_stage #(
        .WIDTH (8),
        .N     (4)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_value (out_value),
        .out_tie   (out_tie)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic scramble_inputs();
        for (int i = 0; i < 4; i++) in_data[i] = 8'sh7F;
    endtask

    // Waits for in_ready, presents one vector for a single accepting edge, then
    // corrupts in_data so only the captured copy can produce the right answer.
    task automatic send(input logic [7:0] d0, input logic [7:0] d1,
                        input logic [7:0] d2, input logic [7:0] d3);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check_eq("send_ready", {31'd0, in_ready}, 32'd1);
        in_data[0] = d0;
        in_data[1] = d1;
        in_data[2] = d2;
        in_data[3] = d3;
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        scramble_inputs();
    endtask

    // Called just after the accepting edge; out_valid must be seen on the 4th
    // negedge (three SCAN cycles, then HOLD).
    task automatic wait_result(input string tag, input logic [1:0] exp_idx,
                               input logic [7:0] exp_val, input logic exp_tie);
        int lat;
        bit seen;
        lat  = 0;
        seen = 1'b0;
        for (int c = 1; c <= 20 && !seen; c++) begin
            @(negedge clk);
            lat = c;
            if (out_valid) seen = 1'b1;
            else check_eq({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
        end
        check_eq({tag, "_lat"},   lat, 4);
        check_eq({tag, "_rdy"},   {31'd0, in_ready}, 32'd0);
        check_eq({tag, "_idx"},   {30'd0, out_index}, {30'd0, exp_idx});
        check_eq({tag, "_val"},   {24'd0, out_value}, {24'd0, exp_val});
        check_eq({tag, "_tie"},   {31'd0, out_tie}, {31'd0, exp_tie});
        if (out_ready) begin
            @(negedge clk);
            check_eq({tag, "_vdrop"}, {31'd0, out_valid}, 32'd0);
            check_eq({tag, "_rback"}, {31'd0, in_ready}, 32'd1);
        end
    endtask

    initial begin
        int hits;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        scramble_inputs();

        // Reset
        repeat (3) @(negedge clk);
        check_eq("rst_hold_valid", {31'd0, out_valid}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_ready", {31'd0, in_ready}, 32'd1);
        check_eq("rst_idx",   {30'd0, out_index}, 32'd0);
        check_eq("rst_val",   {24'd0, out_value}, 32'd0);
        check_eq("rst_tie",   {31'd0, out_tie}, 32'd0);

        // Basic, signed, last-element, tie cases
        send(8'h10, 8'h40, 8'hF0, 8'h20); wait_result("basic",  2'd1, 8'h40, 1'b0);
        send(8'h80, 8'hFF, 8'hC0, 8'h90); wait_result("signed", 2'd1, 8'hFF, 1'b0);
        send(8'h10, 8'h20, 8'h30, 8'h7F); wait_result("last",   2'd3, 8'h7F, 1'b0);
        send(8'h20, 8'h30, 8'h30, 8'h10); wait_result("tie",    2'd1, 8'h30, 1'b1);
        send(8'h50, 8'h50, 8'h50, 8'h50); wait_result("alleq",  2'd0, 8'h50, 1'b1);
        send(8'h30, 8'h30, 8'h60, 8'h10); wait_result("tieclr", 2'd2, 8'h60, 1'b0);

        // Backpressure with a pending vector; max at index 0
        out_ready = 1'b0;
        send(8'h7F, 8'h00, 8'h80, 8'h01); wait_result("bp", 2'd0, 8'h7F, 1'b0);
        in_data[0] = 8'sh05;
        in_data[1] = 8'sh06;
        in_data[2] = 8'sh70;
        in_data[3] = 8'sh01;
        in_valid   = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_eq("bp_valid", {31'd0, out_valid}, 32'd1);
            check_eq("bp_idx",   {30'd0, out_index}, 32'd0);
            check_eq("bp_val",   {24'd0, out_value}, 32'h7F);
            check_eq("bp_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_rel_valid", {31'd0, out_valid}, 32'd0);
        check_eq("bp_rel_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        scramble_inputs();
        wait_result("pend", 2'd2, 8'h70, 1'b0);

        // Reset two cycles into a scan: nothing may be emitted
        send(8'h10, 8'h40, 8'hF0, 8'h20);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("mrst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("mrst_ready", {31'd0, in_ready}, 32'd1);
        check_eq("mrst_val",   {24'd0, out_value}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        hits  = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid) hits++;
        end
        check_eq("mrst_no_emit", hits, 0);
        send(8'h01, 8'h02, 8'h03, 8'h04); wait_result("post", 2'd3, 8'h04, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
